// File: rtl/cache_refill_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel between I- and D-cache refills.
// One line-sized INCR burst outstanding; returned beats are steered to the granted cache.
module cache_refill_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int BEATS  = 2,
    parameter int AXI_ID = 0
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              i_rd_rdy,
    output logic              i_ret_valid,
    output logic              i_ret_last,
    output logic [DATA_W-1:0] i_ret_data,

    input  logic              d_rd_req,
    input  logic [ADDR_W-1:0] d_rd_addr,
    output logic              d_rd_rdy,
    output logic              d_ret_valid,
    output logic              d_ret_last,
    output logic [DATA_W-1:0] d_ret_data,

    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [3:0]        arid,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,

    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rlast,
    input  logic [1:0]        rresp,
    input  logic [3:0]        rid,

    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_e;

    localparam int         LW        = ADDR_W - 4;
    localparam logic [7:0] LAST_BEAT = 8'(BEATS - 1);

    state_e            state_q, state_d;
    logic              pend_i_q, pend_i_d;
    logic              pend_d_q, pend_d_d;
    logic [LW-1:0]     addr_i_q, addr_i_d;
    logic [LW-1:0]     addr_d_q, addr_d_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              rready_q, rready_d;
    logic [7:0]        beat_q, beat_d;
    logic              err_q, err_d;

    logic              pick_d;
    logic              beat_fire;
    logic              unused_ok;

    // grant/last encoding: 1 = D-cache, 0 = I-cache
    assign pick_d    = pend_d_q && (!pend_i_q || !last_q);
    assign beat_fire = (state_q == DATA) && rvalid && rready_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pend_i_q  <= 1'b0;
            pend_d_q  <= 1'b0;
            addr_i_q  <= '0;
            addr_d_q  <= '0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            rready_q  <= 1'b0;
            beat_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_i_q  <= pend_i_d;
            pend_d_q  <= pend_d_d;
            addr_i_q  <= addr_i_d;
            addr_d_q  <= addr_d_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            rready_q  <= rready_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_i_d  = pend_i_q;
        pend_d_d  = pend_d_q;
        addr_i_d  = addr_i_q;
        addr_d_d  = addr_d_q;
        grant_d   = grant_q;
        last_d    = last_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        rready_d  = rready_q;
        beat_d    = beat_q;
        err_d     = err_q;

        if (i_rd_req && !pend_i_q) begin
            pend_i_d = 1'b1;
            addr_i_d = i_rd_addr[ADDR_W-1:4];
        end
        if (d_rd_req && !pend_d_q) begin
            pend_d_d = 1'b1;
            addr_d_d = d_rd_addr[ADDR_W-1:4];
        end

        unique case (state_q)
            IDLE: begin
                if (pend_i_q || pend_d_q) begin
                    grant_d   = pick_d;
                    state_d   = ADDR;
                    arvalid_d = 1'b1;
                    araddr_d  = {pick_d ? addr_d_q : addr_i_q, 4'h0};
                end
            end
            ADDR: begin
                if (arvalid_q && arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    beat_d    = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (beat_fire) begin
                    if (beat_q != 8'hFF) begin
                        beat_d = beat_q + 8'd1;
                    end
                    if (rresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                    // rlast must coincide exactly with the final beat
                    if (rlast != (beat_q == LAST_BEAT)) begin
                        err_d = 1'b1;
                    end
                    if (rlast) begin
                        rready_d = 1'b0;
                        last_d   = grant_q;
                        state_d  = IDLE;
                        if (grant_q) begin
                            pend_d_d = 1'b0;
                        end else begin
                            pend_i_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        i_ret_valid = 1'b0;
        i_ret_last  = 1'b0;
        i_ret_data  = '0;
        d_ret_valid = 1'b0;
        d_ret_last  = 1'b0;
        d_ret_data  = '0;
        if (state_q == DATA) begin
            if (grant_q) begin
                d_ret_valid = rvalid;
                d_ret_last  = rlast;
                d_ret_data  = rdata;
            end else begin
                i_ret_valid = rvalid;
                i_ret_last  = rlast;
                i_ret_data  = rdata;
            end
        end
    end

    assign i_rd_rdy = !pend_i_q;
    assign d_rd_rdy = !pend_d_q;
    assign arvalid  = arvalid_q;
    assign araddr   = araddr_q;
    assign rready   = rready_q;
    assign bus_err  = err_q;
    assign arid     = 4'(AXI_ID);
    assign arlen    = LAST_BEAT;
    assign arsize   = 3'($clog2(DATA_W / 8));
    assign arburst  = 2'b01;

    // single outstanding transaction: rid and sub-line address bits carry no information
    assign unused_ok = ^{rid, i_rd_addr[3:0], d_rd_addr[3:0]};

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Randomized self-checking bench for cache_refill_arbiter.
// The bench plays the AXI slave and predicts grants from the round-robin rules.
module tb_cache_refill_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_rd_req, d_rd_req;
    logic [31:0] i_rd_addr, d_rd_addr;
    logic        i_rd_rdy, d_rd_rdy;
    logic        i_ret_valid, i_ret_last, d_ret_valid, d_ret_last;
    logic [63:0] i_ret_data, d_ret_data;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready, rlast;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    bit               got, proto, inj_rdy;
    int               waited;
    logic [31:0]      a;
    logic [2:0]       iv, il, dv, dl;
    logic [2:0][63:0] idat, ddat, dat;

    always #5 clock = ~clock;

    cache_refill_arbiter dut (
        .clock(clock), .reset(reset),
        .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
        .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
        .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
        .rresp(rresp), .rid(rid), .bus_err(bus_err)
    );

    function automatic logic [31:0] line(input logic [31:0] x);
        return {x[31:4], 4'h0};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        i_rd_req = 0; d_rd_req = 0; i_rd_addr = 0; d_rd_addr = 0;
        arready = 0; rvalid = 0; rlast = 0; rdata = 0; rresp = 0; rid = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    task automatic pulse(input bit pi, input bit pd, input logic [31:0] ai, input logic [31:0] ad);
        i_rd_req = pi; i_rd_addr = ai;
        d_rd_req = pd; d_rd_addr = ad;
        @(negedge clock); #1;
        i_rd_req = 0; d_rd_req = 0;
    endtask

    // AXI slave: waits for AR, stalls arready, returns nb beats; only records observations
    task automatic serve(input int stall, input int nb, input logic [1:0] resp0,
                         input logic [2:0][63:0] bd, input bit inj, input logic [31:0] inj_addr,
                         output bit o_got, output int o_wait, output logic [31:0] o_a,
                         output bit o_proto, output logic [2:0] o_iv, output logic [2:0] o_il,
                         output logic [2:0] o_dv, output logic [2:0] o_dl,
                         output logic [2:0][63:0] o_idat, output logic [2:0][63:0] o_ddat,
                         output bit o_inj_rdy);
        o_got = 0; o_wait = 0; o_a = '0; o_proto = 1; o_inj_rdy = 1;
        o_iv = '0; o_il = '0; o_dv = '0; o_dl = '0; o_idat = '0; o_ddat = '0;
        while (!arvalid && o_wait < 20) begin
            @(negedge clock); #1;
            o_wait++;
        end
        o_got = arvalid;
        if (!o_got) return;
        o_a = araddr;
        for (int s = 0; s <= stall; s++) begin
            arready = (s == stall);
            rvalid  = (s < stall);
            rlast   = 1'b1;
            rdata   = {$urandom, $urandom};
            #1;
            if (!arvalid || araddr !== o_a || rready || i_ret_valid || d_ret_valid) o_proto = 0;
            @(negedge clock); #1;
        end
        arready = 0; rvalid = 0; rlast = 0;
        for (int b = 0; b < nb; b++) begin
            rvalid = 1;
            rdata  = bd[b];
            rlast  = (b == nb - 1);
            rresp  = (b == 0) ? resp0 : 2'b00;
            if (inj && b == 0) begin
                d_rd_req = 1; d_rd_addr = inj_addr;
            end
            if (inj && b == 1) o_inj_rdy = d_rd_rdy;
            #1;
            o_iv[b] = i_ret_valid; o_il[b] = i_ret_last; o_idat[b] = i_ret_data;
            o_dv[b] = d_ret_valid; o_dl[b] = d_ret_last; o_ddat[b] = d_ret_data;
            if (arvalid || !rready) o_proto = 0;
            @(negedge clock); #1;
            d_rd_req = 0;
        end
        rvalid = 0; rlast = 0; rresp = 0;
    endtask

    task automatic run(input int stall, input int nb, input logic [1:0] resp0,
                       input bit inj, input logic [31:0] inj_addr);
        serve(stall, nb, resp0, dat, inj, inj_addr, got, waited, a, proto,
              iv, il, dv, dl, idat, ddat, inj_rdy);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({arvalid, rready, bus_err} !== 3'b000) begin errors++;
            $display("FAIL rst_ctrl: got %b exp 000", {arvalid, rready, bus_err}); end
        checks++; if (araddr !== 32'h0) begin errors++;
            $display("FAIL rst_araddr: got %h exp 0", araddr); end
        checks++; if ({i_rd_rdy, d_rd_rdy} !== 2'b11) begin errors++;
            $display("FAIL rst_rdy: got %b exp 11", {i_rd_rdy, d_rd_rdy}); end
        checks++; if ({i_ret_valid, i_ret_last, d_ret_valid, d_ret_last, i_ret_data, d_ret_data} !== '0)
            begin errors++; $display("FAIL rst_ret: ret outputs not zero"); end
        checks++; if ({arid, arlen, arsize, arburst} !== {4'd0, 8'd1, 3'd3, 2'b01}) begin errors++;
            $display("FAIL rst_const: got id %h len %h size %h burst %b exp 0 1 3 01",
                     arid, arlen, arsize, arburst); end
    endtask

    task automatic test_single_miss();
        do_reset();
        pulse(1, 0, 32'h8000_0124, 0);
        checks++; if (i_rd_rdy !== 1'b0) begin errors++;
            $display("FAIL single_rdy_low: got %b exp 0", i_rd_rdy); end
        dat = {64'h0, 64'h22, 64'h11};
        run(0, 2, 2'b00, 0, 0);
        checks++; if (got !== 1'b1 || waited !== 1) begin errors++;
            $display("FAIL single_latency: got ar %b after %0d exp 1 after 1", got, waited); end
        checks++; if (a !== 32'h8000_0120) begin errors++;
            $display("FAIL single_araddr: got %h exp 80000120", a); end
        checks++; if (proto !== 1'b1) begin errors++;
            $display("FAIL single_proto: got %b exp 1", proto); end
        checks++; if ({iv, il, dv, dl} !== {3'b011, 3'b010, 6'b0}) begin errors++;
            $display("FAIL single_flags: got %b exp 011010000000", {iv, il, dv, dl}); end
        checks++; if (idat[1:0] !== {64'h22, 64'h11} || ddat !== '0) begin errors++;
            $display("FAIL single_data: got %h/%h exp 22/11, d %h", idat[1], idat[0], ddat); end
        checks++; if ({i_rd_rdy, bus_err} !== 2'b10) begin errors++;
            $display("FAIL single_after: got rdy/err %b exp 10", {i_rd_rdy, bus_err}); end
    endtask

    task automatic test_tie();
        logic [31:0] ai, ad;
        do_reset();
        ai = $urandom; ad = $urandom;
        dat = {64'h0, {$urandom, $urandom}, {$urandom, $urandom}};
        pulse(1, 1, ai, ad);
        run($urandom_range(0, 2), 2, 0, 0, 0);
        checks++; if (a !== line(ai) || iv !== 3'b011 || dv !== 3'b000) begin errors++;
            $display("FAIL tie1_first: got %h iv %b dv %b exp %h I", a, iv, dv, line(ai)); end
        run(0, 2, 0, 0, 0);
        checks++; if (waited !== 1 || a !== line(ad) || dv !== 3'b011 || iv !== 3'b000) begin
            errors++; $display("FAIL tie1_second: got %h wait %0d exp %h D wait 1", a, waited, line(ad)); end
        ai = $urandom;
        pulse(1, 0, ai, 0);
        run(0, 2, 0, 0, 0);
        checks++; if (a !== line(ai) || iv !== 3'b011) begin errors++;
            $display("FAIL tie_ionly: got %h exp %h", a, line(ai)); end
        ai = $urandom; ad = $urandom;
        pulse(1, 1, ai, ad);
        run(0, 2, 0, 0, 0);
        checks++; if (a !== line(ad) || dv !== 3'b011) begin errors++;
            $display("FAIL tie2_first: got %h exp %h D", a, line(ad)); end
        run(0, 2, 0, 0, 0);
        checks++; if (a !== line(ai) || iv !== 3'b011) begin errors++;
            $display("FAIL tie2_second: got %h exp %h I", a, line(ai)); end
    endtask

    task automatic test_d_during_i();
        logic [31:0] ai, ad;
        do_reset();
        ai = $urandom; ad = $urandom;
        pulse(1, 0, ai, 0);
        run(0, 2, 0, 1, ad);
        checks++; if (inj_rdy !== 1'b0 || iv !== 3'b011 || dv !== 3'b000) begin errors++;
            $display("FAIL dinj_latch: got rdy %b iv %b dv %b exp 0 011 000", inj_rdy, iv, dv); end
        checks++; if (d_rd_rdy !== 1'b0 || i_rd_rdy !== 1'b1) begin errors++;
            $display("FAIL dinj_rdy: got i %b d %b exp 1 0", i_rd_rdy, d_rd_rdy); end
        run(0, 2, 0, 0, 0);
        checks++; if (waited !== 1 || a !== line(ad) || dv !== 3'b011) begin errors++;
            $display("FAIL dinj_issue: got %h wait %0d exp %h wait 1", a, waited, line(ad)); end
    endtask

    task automatic test_ar_stall();
        logic [31:0] ad;
        do_reset();
        ad = $urandom;
        pulse(0, 1, 0, ad);
        run(5, 2, 0, 0, 0);
        checks++; if (proto !== 1'b1) begin errors++;
            $display("FAIL stall_stable: got %b exp 1", proto); end
        checks++; if (a !== line(ad) || dv !== 3'b011 || iv !== 3'b000) begin errors++;
            $display("FAIL stall_burst: got %h dv %b exp %h 011", a, dv, line(ad)); end
    endtask

    task automatic test_bus_err();
        do_reset();
        dat = {64'h0, 64'hBEEF, 64'hCAFE};
        pulse(1, 0, $urandom, 0);
        run(0, 2, 2'b10, 0, 0);
        checks++; if (bus_err !== 1'b1 || iv !== 3'b011 || idat[0] !== 64'hCAFE) begin errors++;
            $display("FAIL err_resp: got err %b iv %b d0 %h exp 1 011 cafe", bus_err, iv, idat[0]); end
        pulse(0, 1, $urandom, $urandom);
        run(0, 2, 0, 0, 0);
        checks++; if (bus_err !== 1'b1 || got !== 1'b1 || dv !== 3'b011) begin errors++;
            $display("FAIL err_sticky: got err %b ar %b dv %b exp 1 1 011", bus_err, got, dv); end
        do_reset();
        checks++; if (bus_err !== 1'b0) begin errors++;
            $display("FAIL err_clear: got %b exp 0", bus_err); end
        pulse(1, 0, $urandom, 0);
        run(0, 1, 0, 0, 0);
        checks++; if ({bus_err, i_rd_rdy, iv, il} !== {2'b11, 3'b001, 3'b001}) begin errors++;
            $display("FAIL err_early: got %b exp 11001001", {bus_err, i_rd_rdy, iv, il}); end
        do_reset();
        pulse(0, 1, 0, $urandom);
        run(0, 3, 0, 0, 0);
        checks++; if ({bus_err, d_rd_rdy, dv, dl} !== {2'b11, 3'b111, 3'b100}) begin errors++;
            $display("FAIL err_late: got %b exp 11111100", {bus_err, d_rd_rdy, dv, dl}); end
    endtask

    task automatic test_reset_mid_burst();
        int k;
        do_reset();
        pulse(0, 1, 0, $urandom);
        k = 0;
        while (!arvalid && k < 10) begin
            @(negedge clock); #1;
            k++;
        end
        arready = 1;
        @(negedge clock); #1;
        arready = 0; rvalid = 1; rlast = 0; rdata = 64'h55;
        #1;
        checks++; if (d_ret_valid !== 1'b1 || d_ret_data !== 64'h55) begin errors++;
            $display("FAIL rmid_data: got %b %h exp 1 55", d_ret_valid, d_ret_data); end
        reset = 1;
        @(negedge clock); #1;
        checks++; if ({arvalid, rready, bus_err, d_ret_valid, i_ret_valid, i_rd_rdy, d_rd_rdy}
                      !== 7'b0000011 || araddr !== 32'h0 || d_ret_data !== '0) begin errors++;
            $display("FAIL rmid_reset: got %b %h exp 0000011 0", {arvalid, rready, bus_err,
                     d_ret_valid, i_ret_valid, i_rd_rdy, d_rd_rdy}, araddr); end
        reset = 0; rvalid = 0;
        repeat (3) @(negedge clock);
        #1;
        checks++; if (arvalid !== 1'b0 || d_rd_rdy !== 1'b1) begin errors++;
            $display("FAIL rmid_idle: got ar %b rdy %b exp 0 1", arvalid, d_rd_rdy); end
    endtask

    task automatic test_random();
        bit          mpi, mpd, mlast, pi, pd, any, gd;
        logic [31:0] mai, mad, ea;
        do_reset();
        mpi = 0; mpd = 0; mlast = 1; mai = 0; mad = 0;
        for (int it = 0; it < 40; it++) begin
            checks++; if ({i_rd_rdy, d_rd_rdy} !== {!mpi, !mpd}) begin errors++;
                $display("FAIL rnd_rdy[%0d]: got %b exp %b", it, {i_rd_rdy, d_rd_rdy}, {!mpi, !mpd}); end
            any = mpi || mpd;
            pi  = !mpi && ($urandom_range(0, 1) == 1);
            pd  = !mpd && ($urandom_range(0, 1) == 1);
            if (!any && !pi && !pd) pi = 1;
            // a request already waiting wins before a fresh pulse can be seen
            if (any)           gd = mpd;
            else if (pi && pd) gd = !mlast;
            else               gd = pd;
            if (pi) begin mpi = 1; mai = $urandom; end
            if (pd) begin mpd = 1; mad = $urandom; end
            dat = {64'h0, {$urandom, $urandom}, {$urandom, $urandom}};
            pulse(pi, pd, mai, mad);
            run($urandom_range(0, 3), 2, 0, 0, 0);
            ea = gd ? line(mad) : line(mai);
            checks++; if (got !== 1'b1 || a !== ea || waited !== (any ? 0 : 1)) begin errors++;
                $display("FAIL rnd_ar[%0d]: got %h wait %0d exp %h wait %0d", it, a, waited, ea,
                         any ? 0 : 1); end
            checks++; if ({iv, dv} !== (gd ? 6'b000011 : 6'b011000) || proto !== 1'b1) begin errors++;
                $display("FAIL rnd_port[%0d]: got iv %b dv %b exp grant %s", it, iv, dv,
                         gd ? "D" : "I"); end
            checks++; if ((gd ? ddat[1:0] : idat[1:0]) !== dat[1:0]) begin errors++;
                $display("FAIL rnd_data[%0d]: got %h exp %h", it,
                         gd ? ddat[1:0] : idat[1:0], dat[1:0]); end
            if (gd) mpd = 0; else mpi = 0;
            mlast = gd;
        end
        checks++; if (bus_err !== 1'b0) begin errors++;
            $display("FAIL rnd_err: got %b exp 0", bus_err); end
    endtask

    initial begin
        reset = 1;
        i_rd_req = 0; d_rd_req = 0; i_rd_addr = 0; d_rd_addr = 0;
        arready = 0; rvalid = 0; rlast = 0; rdata = 0; rresp = 0; rid = 0;
        test_reset();
        test_single_miss();
        test_tie();
        test_d_during_i();
        test_ar_stall();
        test_bus_err();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
